// File: rtl/cdc_pkg.sv
// -----------------------------------------------------------------------------
// cdc_pkg
//   Definitions shared by the clock-domain-crossing blocks.
//   MIN_STAGES : fewest synchronizer flops any CDC chain may be built with.
//   stages_ok  : parameter check that every CDC block applies to its chain depth.
// -----------------------------------------------------------------------------
package cdc_pkg;

    localparam int MIN_STAGES = 2;

    function automatic bit stages_ok(input int stages);
        return stages >= MIN_STAGES;
    endfunction

endpackage : cdc_pkg

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
//   Single-bit synchronizer: a STAGES-deep flop chain clocked by clk2.
//   Parameters: STAGES (chain depth), RST_BIT (value every flop takes on reset).
//   Ports:
//     clk2  in   destination clock, posedge
//     rst   in   synchronous, active-high reset
//     d     in   asynchronous level
//     q     out  last flop of the chain
// -----------------------------------------------------------------------------
module sync_chain
    import cdc_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk2,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk2) begin
        if (rst) begin
            ff <= {STAGES{RST_BIT}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule : sync_chain

// File: rtl/sync_bank.sv
// -----------------------------------------------------------------------------
// sync_bank
//   WIDTH independent level synchronizers into the clk2 domain, with per-channel
//   rise/fall pulses and an aggregate change flag. Channels are independent bits,
//   not a coherent bus.
//
//   Optional feature (macro SYNC_GLITCH_FILTER_EN): each channel is followed by a
//   stability filter; a synchronized change must persist FILT_CYCLES cycles before
//   it reaches g_sync. Without the macro, FILT_CYCLES is unused and no filter
//   state is built.
//
//   Parameters: WIDTH, STAGES (>= cdc_pkg::MIN_STAGES), RESET_VAL, FILT_CYCLES (>=1)
//   Ports:
//     clk2     in   destination clock, posedge
//     rst      in   synchronous, active-high reset
//     g        in   [WIDTH] asynchronous level inputs
//     g_sync   out  [WIDTH] synchronized (optionally filtered) levels
//     g_rise   out  [WIDTH] one-cycle pulse on g_sync 0->1
//     g_fall   out  [WIDTH] one-cycle pulse on g_sync 1->0
//     chg_any  out  any rise or fall this cycle
// -----------------------------------------------------------------------------
module sync_bank
    import cdc_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    parameter int               FILT_CYCLES = 4
) (
    input  logic             clk2,
    input  logic             rst,
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] g_sync,
    output logic [WIDTH-1:0] g_rise,
    output logic [WIDTH-1:0] g_fall,
    output logic             chg_any
);

    generate
        if (!stages_ok(STAGES)) begin : g_bad_stages
            $error("sync_bank: STAGES must be at least %0d", MIN_STAGES);
        end
        if (FILT_CYCLES < 1) begin : g_bad_filt
            $error("sync_bank: FILT_CYCLES must be at least 1");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("sync_bank: WIDTH must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        sync_chain #(
            .STAGES  (STAGES),
            .RST_BIT (RESET_VAL[i])
        ) u_chain (
            .clk2 (clk2),
            .rst  (rst),
            .d    (g[i]),
            .q    (s[i])
        );
    end

`ifdef SYNC_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILT_CYCLES + 1);

    logic [WIDTH-1:0] f;
    logic [CW-1:0]    cnt [WIDTH];

    // The cycle that would take the counter to FILT_CYCLES is the cycle f is
    // updated, so a change lands on g_sync exactly FILT_CYCLES cycles after s.
    always_ff @(posedge clk2) begin
        if (rst) begin
            f <= RESET_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == f[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(FILT_CYCLES - 1)) begin
                    f[i]   <= s[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign g_sync = f;
`else
    assign g_sync = s;
`endif

    logic [WIDTH-1:0] g_sync_d;

    // Resetting the delayed copy with g_sync keeps reset from creating an edge.
    always_ff @(posedge clk2) begin
        if (rst) begin
            g_sync_d <= RESET_VAL;
        end else begin
            g_sync_d <= g_sync;
        end
    end

    assign g_rise  = g_sync & ~g_sync_d;
    assign g_fall  = ~g_sync & g_sync_d;
    assign chg_any = |(g_rise | g_fall);

endmodule : sync_bank

// File: tb/tb_sync_bank.sv
module tb_sync_bank;

    logic       clk2 = 1'b0;
    logic       rst;
    logic [3:0] g;

    logic [3:0] a_sync, a_rise, a_fall;
    logic       a_chg;
    logic [3:0] b_sync, b_rise, b_fall;
    logic       b_chg;

    always #5 clk2 = ~clk2;

    sync_bank #(
        .WIDTH       (4),
        .STAGES      (2),
        .RESET_VAL   (4'h0),
        .FILT_CYCLES (4)
    ) dut_a (
        .clk2    (clk2),
        .rst     (rst),
        .g       (g),
        .g_sync  (a_sync),
        .g_rise  (a_rise),
        .g_fall  (a_fall),
        .chg_any (a_chg)
    );

    sync_bank #(
        .WIDTH       (4),
        .STAGES      (3),
        .RESET_VAL   (4'h5),
        .FILT_CYCLES (4)
    ) dut_b (
        .clk2    (clk2),
        .rst     (rst),
        .g       (g),
        .g_sync  (b_sync),
        .g_rise  (b_rise),
        .g_fall  (b_fall),
        .chg_any (b_chg)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Every edge's sampled g and rst, indexed by edge number.
    localparam int MAXE = 4096;
    logic [3:0] samp [MAXE];
    bit         rsts [MAXE];
    int         ecount = 0;

    always @(posedge clk2) begin
        if (ecount < MAXE) begin
            samp[ecount] <= g;
            rsts[ecount] <= rst;
        end
        ecount <= ecount + 1;
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, ecount - 1);
        end
    endtask

    task automatic step(input logic [3:0] gv, input logic rv);
        g   = gv;
        rst = rv;
        @(posedge clk2);
        #1;
    endtask

    // After edge n, an st-deep chain shows g as sampled at edge n-st+1, unless a
    // reset was sampled at any edge in that window, in which case it holds rv.
    function automatic logic [3:0] m_sync(input int st, input logic [3:0] rv, input int n);
        if (n - st + 1 < 0) return rv;
        for (int m = n - st + 1; m <= n; m++) begin
            if (rsts[m]) return rv;
        end
        return samp[n - st + 1];
    endfunction

    function automatic logic [3:0] m_prev(input int st, input logic [3:0] rv, input int n);
        if (n < 1 || rsts[n]) return rv;
        return m_sync(st, rv, n - 1);
    endfunction

    task automatic model_chk();
        int n;
        logic [3:0] es, ep;
        n  = ecount - 1;
        es = m_sync(2, 4'h0, n);
        ep = m_prev(2, 4'h0, n);
        chk("a_sync", a_sync, es);
        chk("a_rise", a_rise, es & ~ep);
        chk("a_fall", a_fall, ~es & ep);
        chk("a_chg", {3'b0, a_chg}, {3'b0, |(es ^ ep)});
        es = m_sync(3, 4'h5, n);
        ep = m_prev(3, 4'h5, n);
        chk("b_sync", b_sync, es);
        chk("b_rise", b_rise, es & ~ep);
        chk("b_fall", b_fall, ~es & ep);
        chk("b_chg", {3'b0, b_chg}, {3'b0, |(es ^ ep)});
    endtask

    typedef struct {
        logic [3:0] g;
        logic       rst;
        logic [3:0] sync;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       chg;
    } vec_t;

    vec_t vec [22];

    initial begin
        g   = 4'h0;
        rst = 1'b1;

`ifndef SYNC_GLITCH_FILTER_EN
        //             g      rst   sync   rise   fall   chg
        vec[0]  = '{4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[1]  = '{4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[2]  = '{4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[3]  = '{4'hF, 1'b0, 4'hF, 4'hF, 4'h0, 1'b1};
        vec[4]  = '{4'hF, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        vec[5]  = '{4'h0, 1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        vec[6]  = '{4'h0, 1'b0, 4'h0, 4'h0, 4'hF, 1'b1};
        vec[7]  = '{4'h1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[8]  = '{4'h1, 1'b0, 4'h1, 4'h1, 4'h0, 1'b1};
        vec[9]  = '{4'h1, 1'b0, 4'h1, 4'h0, 4'h0, 1'b0};
        vec[10] = '{4'hA, 1'b0, 4'h1, 4'h0, 4'h0, 1'b0};
        vec[11] = '{4'hA, 1'b0, 4'hA, 4'hA, 4'h1, 1'b1};
        vec[12] = '{4'h6, 1'b0, 4'hA, 4'h0, 4'h0, 1'b0};
        vec[13] = '{4'h6, 1'b0, 4'h6, 4'h4, 4'h8, 1'b1};
        vec[14] = '{4'h6, 1'b0, 4'h6, 4'h0, 4'h0, 1'b0};
        vec[15] = '{4'h2, 1'b0, 4'h6, 4'h0, 4'h0, 1'b0};
        vec[16] = '{4'h2, 1'b0, 4'h2, 4'h0, 4'h4, 1'b1};
        vec[17] = '{4'h6, 1'b0, 4'h2, 4'h0, 4'h0, 1'b0};
        vec[18] = '{4'h6, 1'b0, 4'h6, 4'h4, 4'h0, 1'b1};
        vec[19] = '{4'h6, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[20] = '{4'h6, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0};
        vec[21] = '{4'h6, 1'b0, 4'h6, 4'h6, 4'h0, 1'b1};

        for (int i = 0; i < 22; i++) begin
            step(vec[i].g, vec[i].rst);
            chk($sformatf("vec%0d_sync", i), a_sync, vec[i].sync);
            chk($sformatf("vec%0d_rise", i), a_rise, vec[i].rise);
            chk($sformatf("vec%0d_fall", i), a_fall, vec[i].fall);
            chk($sformatf("vec%0d_chg", i), {3'b0, a_chg}, {3'b0, vec[i].chg});
            model_chk();
            if (vec[i].rst) chk("b_reset_val", b_sync, 4'h5);
        end

        // Three-stage chain surfaces a change one cycle after the two-stage one.
        for (int i = 0; i < 3; i++) step(4'h0, 1'b0);
        step(4'h1, 1'b0);
        chk("lat_a_k", a_sync, 4'h0);
        chk("lat_b_k", b_sync, 4'h0);
        step(4'h1, 1'b0);
        chk("lat_a_k1", a_sync, 4'h1);
        chk("lat_b_k1", b_sync, 4'h0);
        step(4'h1, 1'b0);
        chk("lat_b_k2", b_sync, 4'h1);
        chk("lat_b_rise", b_rise, 4'h1);

        begin
            logic [3:0] gv;
            gv = 4'h1;
            for (int c = 0; c < 400; c++) begin
                for (int b = 0; b < 4; b++) begin
                    if ($urandom_range(0, 3) == 0) gv[b] = ~gv[b];
                end
                step(gv, ($urandom_range(0, 39) == 0));
                model_chk();
            end
        end
`else
        step(4'h0, 1'b1);
        step(4'h0, 1'b1);
        chk("f_reset_a", a_sync, 4'h0);
        chk("f_reset_b", b_sync, 4'h5);
        for (int i = 0; i < 4; i++) step(4'h0, 1'b0);

        // Three-cycle glitch on channel 1 must never reach g_sync.
        for (int j = 0; j < 12; j++) begin
            step((j < 3) ? 4'h2 : 4'h0, 1'b0);
            chk($sformatf("glitch_sync%0d", j), a_sync, 4'h0);
            chk($sformatf("glitch_rise%0d", j), a_rise, 4'h0);
        end

        // Six-cycle high: g held for edges 0..5, s rises after edge 1, f after edge 5.
        for (int j = 0; j < 15; j++) begin
            step((j < 6) ? 4'h2 : 4'h0, 1'b0);
            chk($sformatf("hold_sync%0d", j), a_sync, (j >= 5 && j <= 10) ? 4'h2 : 4'h0);
            chk($sformatf("hold_rise%0d", j), a_rise, (j == 5) ? 4'h2 : 4'h0);
            chk($sformatf("hold_fall%0d", j), a_fall, (j == 11) ? 4'h2 : 4'h0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_sync_bank
